sram_rd_scheduler: RTL and testbench
====================================

SRAM_RD_SCHEDULER -- requirements
Module: sram_rd_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the watchdog limit in cycles without read data (8-bit range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port req_vld, input, 16, bit p set when port p has a packet pending in this SRAM.
REQ-005 SHALL have port req_head, input, 256, head address of port p's packet at bits [16p+15:16p].
REQ-006 SHALL have port port_rdy, input, 16, bit p set when port p can accept read data.
REQ-007 SHALL have port grant, output, 16, one-hot single-cycle pulse that pops port p's pending entry.
REQ-008 SHALL have port rd_next, output, 1, single-cycle start strobe to the SRAM read path.
REQ-009 SHALL have port rd_port, output, 4, port being served.
REQ-010 SHALL have port rd_packet_head_addr, output, 16, head address for the started packet.
REQ-011 SHALL have port rd_xfer_data_vld, input, 1, a read word was produced.
REQ-012 SHALL have port rd_end_of_packet, input, 1, last word of the current packet.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port pkt_count, output, 16, number of completed packets, wrapping modulo 65536.
REQ-015 SHALL have port wd_err, output, 1, one-cycle watchdog abort pulse.

Function
REQ-016 SHALL implement the FSM states IDLE, ISSUE, STREAM and GAP, all registered.
REQ-017 IDLE: eligible ports are those with req_vld[p] & port_rdy[p]; pick the first eligible port searching circularly from rr_ptr, latch its port number and head address, then go to ISSUE.
REQ-018 IDLE with no eligible port: stay in IDLE and keep all strobes low.
REQ-019 ISSUE: for exactly one cycle assert rd_next=1 and grant=1<<p, with rd_port=p and rd_packet_head_addr=latched head; set rr_ptr <= p+1 (15 wraps to 0); go to STREAM.
REQ-020 Latency: an eligible request sampled in IDLE at cycle N gives grant/rd_next at cycle N+1.
REQ-021 STREAM: rd_port and rd_packet_head_addr hold their values; rd_end_of_packet=1 increments pkt_count and moves to GAP.
REQ-022 GAP: one idle cycle, then IDLE; back-to-back packets are therefore spaced at least 4 cycles from rd_next to rd_next.
REQ-023 Drops of req_vld or port_rdy during ISSUE/STREAM SHALL NOT abort or alter the transfer.
REQ-024 rd_xfer_data_vld and rd_end_of_packet SHALL be ignored in IDLE, ISSUE and GAP.
REQ-025 pkt_count 16'hFFFF plus one completion SHALL give 16'h0000.
REQ-026 rr_ptr SHALL make service fair: a continuously eligible port waits for at most 15 other packets.

Reset
REQ-027 rst=1 SHALL force state IDLE, rr_ptr=0, grant=0, rd_next=0, rd_port=0, rd_packet_head_addr=0, pkt_count=0, wd_err=0 and busy=0.
REQ-028 rst asserted mid-STREAM SHALL abort without counting; the first post-reset grant follows REQ-017 searching from 0.

Configuration
REQ-029 Macro SRAM_RD_SCHED_WATCHDOG_EN defined: a cycle counter clears on entry to STREAM and on every rd_xfer_data_vld.
REQ-030 With the macro defined, when the counter reaches TIMEOUT in STREAM without end-of-packet: pulse wd_err for 1 cycle, go to GAP, and leave pkt_count unchanged.
REQ-031 With the macro defined, rd_end_of_packet in the same cycle as the timeout SHALL win (count, no wd_err).
REQ-032 Macro SRAM_RD_SCHED_WATCHDOG_EN undefined: no counter is built, wd_err is tied 0, and STREAM waits indefinitely.

Verification
REQ-033 Test single request: req_vld=16'h0010, port_rdy=16'hFFFF, head of port 4=16'h1234 -> one cycle later grant=16'h0010, rd_next=1, rd_port=4, rd_packet_head_addr=16'h1234.
REQ-034 Test round-robin: req_vld=port_rdy=16'hFFFF held, EOP 3 cycles after each rd_next -> grants to ports 0,1,2,...,15,0 in order, pkt_count=17.
REQ-035 Test readiness gating: req_vld=16'h0003, port_rdy=16'h0002 -> port 1 granted and port 0 never granted; raising port_rdy[0] gives port 0 the next grant.
REQ-036 Test wrap: pkt_count preloaded via 65535 completions, one more EOP -> pkt_count=0.
REQ-037 Test watchdog with macro defined, TIMEOUT=8: no rd_xfer_data_vld after rd_next -> wd_err pulses 8 cycles into STREAM, busy falls 1 cycle later, pkt_count unchanged; without the macro the FSM stays in STREAM.
REQ-038 Test reset mid-STREAM: rst=1 for 1 cycle -> busy=0 and all outputs zero the next cycle; a pending request on port 5 with all ports ready is granted before ports 6..15.

Source files
------------

// File: rtl/sram_rd_scheduler.sv
// Round-robin read scheduler: picks one ready port at a time and starts its packet on the shared SRAM read path.
// Optional read-data watchdog is built when SRAM_RD_SCHED_WATCHDOG_EN is defined.
module sram_rd_scheduler #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  req_vld,
  input  logic [255:0] req_head,
  input  logic [15:0]  port_rdy,
  output logic [15:0]  grant,
  output logic         rd_next,
  output logic [3:0]   rd_port,
  output logic [15:0]  rd_packet_head_addr,
  input  logic         rd_xfer_data_vld,
  input  logic         rd_end_of_packet,
  output logic         busy,
  output logic [15:0]  pkt_count,
  output logic         wd_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  rr_ptr_r, rr_ptr_nxt_s;
  logic [15:0] grant_r, grant_nxt_s;
  logic        rd_next_r, rd_next_nxt_s;
  logic [3:0]  rd_port_r, rd_port_nxt_s;
  logic [15:0] head_r, head_nxt_s;
  logic [15:0] pkt_count_r, pkt_count_nxt_s;
  logic        wd_err_r, wd_err_nxt_s;
  logic        busy_r;
  logic [15:0] elig_s;
  logic        pick_vld_s;
  logic [3:0]  pick_s;
  logic [3:0]  idx_s;
  logic        timeout_s;

  // First eligible port searching circularly from rr_ptr; scanning backwards lets the nearest one win.
  always_comb begin
    elig_s     = req_vld & port_rdy;
    pick_vld_s = |elig_s;
    pick_s     = 4'd0;
    idx_s      = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      idx_s  = rr_ptr_r + 4'(i);
      pick_s = elig_s[idx_s] ? idx_s : pick_s;
    end
  end

`ifdef SRAM_RD_SCHED_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_cnt_r;

  // Cycles since STREAM entry or the last read word
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r <= 8'd0;
    end else if ((state_r == ISSUE) || ((state_r == STREAM) && rd_xfer_data_vld)) begin
      wd_cnt_r <= 8'd0;
    end else if (state_r == STREAM) begin
      wd_cnt_r <= wd_cnt_r + 8'd1;
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  assign timeout_s = (state_r == STREAM) && !rd_xfer_data_vld && (wd_cnt_r == WD_LAST);
`else
  logic unused_s;
  assign timeout_s = 1'b0;
  assign unused_s  = ^{rd_xfer_data_vld, 8'(TIMEOUT)};
`endif

  // Next state and next values of the registered outputs
  always_comb begin
    state_nxt_s     = state_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    grant_nxt_s     = 16'd0;
    rd_next_nxt_s   = 1'b0;
    rd_port_nxt_s   = rd_port_r;
    head_nxt_s      = head_r;
    pkt_count_nxt_s = pkt_count_r;
    wd_err_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_vld_s) begin
          state_nxt_s   = ISSUE;
          grant_nxt_s   = 16'd1 << pick_s;
          rd_next_nxt_s = 1'b1;
          rd_port_nxt_s = pick_s;
          head_nxt_s    = req_head[{pick_s, 4'd0} +: 16];
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s  = STREAM;
        rr_ptr_nxt_s = rd_port_r + 4'd1;
      end
      STREAM: begin
        // End-of-packet beats a simultaneous timeout.
        if (rd_end_of_packet) begin
          pkt_count_nxt_s = pkt_count_r + 16'd1;
          state_nxt_s     = GAP;
        end else if (timeout_s) begin
          wd_err_nxt_s = 1'b1;
          state_nxt_s  = GAP;
        end else begin
          state_nxt_s = STREAM;
        end
      end
      GAP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rr_ptr_r    <= 4'd0;
      grant_r     <= 16'd0;
      rd_next_r   <= 1'b0;
      rd_port_r   <= 4'd0;
      head_r      <= 16'd0;
      pkt_count_r <= 16'd0;
      wd_err_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      grant_r     <= grant_nxt_s;
      rd_next_r   <= rd_next_nxt_s;
      rd_port_r   <= rd_port_nxt_s;
      head_r      <= head_nxt_s;
      pkt_count_r <= pkt_count_nxt_s;
      wd_err_r    <= wd_err_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign grant               = grant_r;
  assign rd_next             = rd_next_r;
  assign rd_port             = rd_port_r;
  assign rd_packet_head_addr = head_r;
  assign pkt_count           = pkt_count_r;
  assign wd_err              = wd_err_r;
  assign busy                = busy_r;

endmodule

// File: tb/tb_sram_rd_scheduler.sv
// Bench for sram_rd_scheduler: timestamp-based packet model checked every cycle plus directed literal checks.
module tb_sram_rd_scheduler;
  localparam int TO = 8;
`ifdef SRAM_RD_SCHED_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  req_vld;
  logic [255:0] req_head;
  logic [15:0]  port_rdy;
  logic [15:0]  grant;
  logic         rd_next;
  logic [3:0]   rd_port;
  logic [15:0]  rd_packet_head_addr;
  logic         rd_xfer_data_vld;
  logic         rd_end_of_packet;
  logic         busy;
  logic [15:0]  pkt_count;
  logic         wd_err;

  always #5 clk = ~clk;

  sram_rd_scheduler #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_head(req_head), .port_rdy(port_rdy),
    .grant(grant), .rd_next(rd_next), .rd_port(rd_port), .rd_packet_head_addr(rd_packet_head_addr),
    .rd_xfer_data_vld(rd_xfer_data_vld), .rd_end_of_packet(rd_end_of_packet),
    .busy(busy), .pkt_count(pkt_count), .wd_err(wd_err)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Packet model: each packet is a set of cycle timestamps (issue, done, watchdog) rather than states.
  int cyc = 0;
  bit m_active = 1'b0;
  int m_issue = -10;
  int m_done = -1;
  int m_ref = 0;
  int m_wd_at = -10;
  int m_rr = 0;
  int m_port = 0;
  int m_cnt = 0;
  logic [15:0] m_head = 16'd0;

  always @(posedge clk) begin
    int c;
    bit found;
    c = cyc;
    found = 1'b0;
    if (rst) begin
      m_active = 1'b0; m_rr = 0; m_port = 0; m_cnt = 0; m_head = 16'd0;
      m_issue = -10; m_done = -1; m_wd_at = -10;
    end else if (!m_active) begin
      for (int k = 0; k < 16; k++) begin
        int p;
        p = (m_rr + k) % 16;
        if (!found && req_vld[p] && port_rdy[p]) begin
          found = 1'b1;
          m_active = 1'b1; m_issue = c + 1; m_port = p; m_done = -1;
          m_head = req_head[16*p +: 16];
        end
      end
    end else if (c == m_issue) begin
      m_rr = (m_port + 1) % 16;
      m_ref = c + 1;
    end else if (m_done < 0) begin
      if (rd_end_of_packet) begin
        m_cnt = (m_cnt + 1) % 65536;
        m_done = c;
      end else if (WD && !rd_xfer_data_vld && (c - m_ref) == TO - 1) begin
        m_done = c;
        m_wd_at = c + 1;
      end else if (rd_xfer_data_vld) begin
        m_ref = c + 1;
      end
    end else begin
      m_active = 1'b0;
    end
    cyc = cyc + 1;
  end

  // Compare every output against the model mid-cycle
  always @(negedge clk) begin
    bit issue_now;
    if (chk_en) begin
      issue_now = m_active && (cyc == m_issue);
      chk("grant", 32'(grant), issue_now ? 32'(16'd1 << m_port) : 32'd0);
      chk("rd_next", 32'(rd_next), 32'(issue_now));
      chk("rd_port", 32'(rd_port), 32'(m_port));
      chk("rd_head", 32'(rd_packet_head_addr), 32'(m_head));
      chk("busy", 32'(busy), 32'(m_active));
      chk("pkt_count", 32'(pkt_count), 32'(m_cnt));
      chk("wd_err", 32'(wd_err), 32'(cyc == m_wd_at));
    end
  end

  task automatic wait_rd_next(output int port);
    int n;
    n = 0;
    while (rd_next !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("issue_seen", 32'(rd_next), 32'd1);
    port = 32'(rd_port);
  endtask

  task automatic serve(input int delay, output int port);
    wait_rd_next(port);
    repeat (delay) @(negedge clk);
    rd_end_of_packet = 1'b1;
    @(negedge clk);
    rd_end_of_packet = 1'b0;
  endtask

  initial begin
    int p;
    int n;
    rst = 1'b1; req_vld = 16'd0; port_rdy = 16'd0;
    rd_xfer_data_vld = 1'b0; rd_end_of_packet = 1'b0;
    for (int q = 0; q < 16; q++) req_head[16*q +: 16] = 16'(16'hA000 + q * 16'h0101);
    req_head[79:64] = 16'h1234;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt", 32'(pkt_count), 32'd0);
    chk("rst_rd_next", 32'(rd_next), 32'd0);

    // Single request on port 4; inputs drop during the transfer
    req_vld = 16'h0010; port_rdy = 16'hFFFF;
    @(negedge clk);
    chk("single_grant", 32'(grant), 32'h0010);
    chk("single_rd_next", 32'(rd_next), 32'd1);
    chk("single_port", 32'(rd_port), 32'd4);
    chk("single_head", 32'(rd_packet_head_addr), 32'h1234);
    req_vld = 16'h0000; port_rdy = 16'h0000;
    repeat (2) @(negedge clk);
    rd_end_of_packet = 1'b1;
    @(negedge clk);
    rd_end_of_packet = 1'b0;
    chk("single_pkt", 32'(pkt_count), 32'd1);
    port_rdy = 16'hFFFF;

    // Data and end-of-packet strobes in IDLE are ignored
    repeat (2) @(negedge clk);
    rd_end_of_packet = 1'b1; rd_xfer_data_vld = 1'b1;
    repeat (2) @(negedge clk);
    rd_end_of_packet = 1'b0; rd_xfer_data_vld = 1'b0;
    chk("idle_ignore_pkt", 32'(pkt_count), 32'd1);
    chk("idle_ignore_busy", 32'(busy), 32'd0);

    // Reset mid-STREAM, then search restarts from port 0
    req_vld = 16'h0080;
    wait_rd_next(p);
    chk("pre_rst_port", 32'(p), 32'd7);
    req_vld = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_port", 32'(rd_port), 32'd0);
    chk("midrst_head", 32'(rd_packet_head_addr), 32'd0);
    chk("midrst_pkt", 32'(pkt_count), 32'd0);
    req_vld = 16'hFFE0;
    serve(3, p);
    chk("post_rst_port", 32'(p), 32'd5);
    req_vld = 16'h0000;

    // Round robin over all ports
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_vld = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      serve(3, p);
      chk("rr_port", 32'(p), 32'(i % 16));
    end
    req_vld = 16'h0000;
    chk("rr_pkt", 32'(pkt_count), 32'd17);

    // Readiness gating
    req_vld = 16'h0003; port_rdy = 16'h0002;
    serve(2, p);
    chk("gate_first", 32'(p), 32'd1);
    serve(2, p);
    chk("gate_second", 32'(p), 32'd1);
    port_rdy = 16'h0003;
    serve(2, p);
    chk("gate_port0", 32'(p), 32'd0);
    req_vld = 16'h0000; port_rdy = 16'hFFFF;

    // Long packet kept alive by periodic data words
    req_vld = 16'h0004;
    wait_rd_next(p);
    req_vld = 16'h0000;
    for (int j = 0; j < 4; j++) begin
      repeat (4) @(negedge clk);
      rd_xfer_data_vld = 1'b1;
      @(negedge clk);
      rd_xfer_data_vld = 1'b0;
    end
    rd_end_of_packet = 1'b1;
    @(negedge clk);
    rd_end_of_packet = 1'b0;
    chk("dv_pkt", 32'(pkt_count), 32'd21);

    // End-of-packet on the timeout cycle is counted
    req_vld = 16'h0004;
    serve(TO, p);
    req_vld = 16'h0000;
    chk("eop_vs_to_pkt", 32'(pkt_count), 32'd22);

    // No read data at all
    req_vld = 16'h0004;
    wait_rd_next(p);
    req_vld = 16'h0000;
`ifdef SRAM_RD_SCHED_WATCHDOG_EN
    n = 0;
    while (wd_err !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("wd_delay", 32'(n), 32'(TO + 1));
    @(negedge clk);
    chk("wd_busy_fall", 32'(busy), 32'd0);
    chk("wd_pkt", 32'(pkt_count), 32'd22);
`else
    n = 0;
    repeat (30) @(negedge clk);
    chk("nowd_busy", 32'(busy), 32'd1);
    chk("nowd_err", 32'(wd_err), 32'd0);
    rd_end_of_packet = 1'b1;
    @(negedge clk);
    rd_end_of_packet = 1'b0;
    chk("nowd_pkt", 32'(pkt_count), 32'd23);
`endif
    repeat (2) @(negedge clk);

    // Counter wrap from a preloaded value
    @(posedge clk);
    #2;
    force dut.pkt_count_r = 16'hFFFE;
    m_cnt = 32'h0000FFFE;
    @(posedge clk);
    #2;
    release dut.pkt_count_r;
    @(negedge clk);
    req_vld = 16'h0008;
    serve(2, p);
    chk("wrap_ffff", 32'(pkt_count), 32'h0000FFFF);
    serve(2, p);
    chk("wrap_zero", 32'(pkt_count), 32'd0);
    req_vld = 16'h0000;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
